// File: rtl/alu_pkg.sv
// Shared ALU control encoding ({word, alt, funct3}) used by the ALU control decoder
// and by the execute stage.
package alu_pkg;

  localparam int ALU_XLEN      = 64;
  localparam int ALU_TAG_W     = 8;
  localparam int CTRL_W        = 5;
  localparam int CTRL_WORD_BIT = 4;
  localparam int CTRL_ALT_BIT  = 3;
  localparam int CTRL_F3_MSB   = 2;
  localparam int CTRL_F3_LSB   = 0;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD  = 5'b00000,
    ALU_SLL  = 5'b00001,
    ALU_SLT  = 5'b00010,
    ALU_SLTU = 5'b00011,
    ALU_XOR  = 5'b00100,
    ALU_SRL  = 5'b00101,
    ALU_OR   = 5'b00110,
    ALU_AND  = 5'b00111,
    ALU_SUB  = 5'b01000,
    ALU_SRA  = 5'b01101,
    ALU_ADDW = 5'b10000,
    ALU_SLLW = 5'b10001,
    ALU_SRLW = 5'b10101,
    ALU_SUBW = 5'b11000,
    ALU_SRAW = 5'b11101
  } alu_ctrl_e;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Valid/ready bus between decode, the execute stage and the memory stage.
interface alu_exec_stage_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
);

  logic                       in_valid;
  logic                       in_ready;
  logic [alu_pkg::CTRL_W-1:0] in_ctrl;
  logic [XLEN-1:0]            in_a;
  logic [XLEN-1:0]            in_b;
  logic [TAG_W-1:0]           in_tag;
  logic                       out_valid;
  logic                       out_ready;
  logic [XLEN-1:0]            out_result;
  logic [TAG_W-1:0]           out_tag;
  logic                       out_illegal;

  modport master (
    output in_valid, in_ctrl, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_ctrl, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_illegal
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational RV64I / RV64I-W ALU driven by the 5-bit control code.
module alu_core
  import alu_pkg::*;
(
  input  logic [CTRL_W-1:0]   ctrl,
  input  logic [ALU_XLEN-1:0] a,
  input  logic [ALU_XLEN-1:0] b,
  output logic [ALU_XLEN-1:0] result,
  output logic                illegal
);

  logic [5:0]  shamt;
  logic [31:0] a_w;
  logic [31:0] b_w;

  // Word ops only honour five shift bits, so the sixth is masked here once.
  assign shamt = ctrl[CTRL_WORD_BIT] ? {1'b0, b[4:0]} : b[5:0];
  assign a_w   = a[31:0];
  assign b_w   = b[31:0];

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (ctrl)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(ALU_XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(ALU_XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_ADDW: result = sext32(a_w + b_w);
      ALU_SUBW: result = sext32(a_w - b_w);
      ALU_SLLW: result = sext32(a_w << shamt[4:0]);
      ALU_SRLW: result = sext32(a_w >> shamt[4:0]);
      ALU_SRAW: result = sext32($signed(a_w) >>> shamt[4:0]);
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: one ALU op per handshake, results held in an OUT register backed by
// a skid register so in_ready never depends combinationally on out_ready.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = ALU_XLEN,
  parameter int TAG_W = ALU_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  alu_exec_stage_if.slave   bus
);

  typedef struct packed {
    logic             valid;
    logic             illegal;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  result;
  } slot_t;

  slot_t           out_q, out_d;
  slot_t           skid_q, skid_d;
  slot_t           in_slot;
  logic [XLEN-1:0] core_result;
  logic            core_illegal;
  logic            in_ready;
  logic            accept;
  logic            drain;

  alu_core u_core (
    .ctrl    (bus.in_ctrl),
    .a       (bus.in_a),
    .b       (bus.in_b),
    .result  (core_result),
    .illegal (core_illegal)
  );

  assign in_ready = ~skid_q.valid & ~rst;
  assign accept   = bus.in_valid & in_ready;
  assign drain    = out_q.valid & bus.out_ready;
  assign in_slot  = {1'b1, core_illegal, bus.in_tag, core_result};

  // Payload is kept when a slot goes invalid so out_* only move on drain, flush or reset.
  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    if (flush) begin
      out_d.valid  = 1'b0;
      skid_d.valid = 1'b0;
    end else if (!out_q.valid || drain) begin
      if (skid_q.valid) begin
        out_d        = skid_q;
        skid_d.valid = 1'b0;
      end else if (accept) begin
        out_d = in_slot;
      end else begin
        out_d.valid = 1'b0;
      end
    end else if (accept) begin
      skid_d = in_slot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_q.valid;
  assign bus.out_result  = out_q.result;
  assign bus.out_tag     = out_q.tag;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: a queue model of the stage checked every cycle,
// plus literal expected results for each directed op.
module tb_alu_exec_stage;

  typedef struct packed {
    logic [63:0] res;
    logic [7:0]  tag;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [63:0] a;
    logic [63:0] b;
    logic [7:0]  tag;
    logic [63:0] res;
    logic        ill;
  } vec_t;

  logic clk;
  logic rst;
  logic flush;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit rst_d1 = 1'b0;
  bit exp_ready;

  exp_t        model_q[$];
  vec_t        vecs[$];
  logic [63:0] drained_res  [256];
  bit          drained_ill  [256];
  bit          drained_seen [256];
  int          drained_cyc  [256];

  alu_exec_stage_if #(.XLEN(64), .TAG_W(8)) bus ();

  alu_exec_stage #(.XLEN(64), .TAG_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Reference ALU written with plain signed/unsigned integer arithmetic; returns {illegal, result}.
  function automatic logic [64:0] modelAlu(input logic [4:0] c, input logic [63:0] a, input logic [63:0] b);
    longint      sa, sb;
    int          wa, wb, w;
    logic [31:0] u;
    logic [63:0] r;
    logic        ill;
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0];
    w = 0; u = '0; r = '0; ill = 1'b0;
    case (c)
      5'b00000: r = a + b;
      5'b01000: r = a - b;
      5'b00001: r = a << b[5:0];
      5'b00010: r = (sa < sb) ? 64'd1 : 64'd0;
      5'b00011: r = (a < b) ? 64'd1 : 64'd0;
      5'b00100: r = a ^ b;
      5'b00101: r = a >> b[5:0];
      5'b01101: r = sa >>> b[5:0];
      5'b00110: r = a | b;
      5'b00111: r = a & b;
      5'b10000: begin w = wa + wb; r = longint'(w); end
      5'b11000: begin w = wa - wb; r = longint'(w); end
      5'b10001: begin u = a[31:0] << b[4:0]; w = u; r = longint'(w); end
      5'b10101: begin u = a[31:0] >> b[4:0]; w = u; r = longint'(w); end
      5'b11101: begin w = wa >>> b[4:0]; r = longint'(w); end
      default:  ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  // Every cycle: compare DUT state with the model, then advance the model by this edge's handshakes.
  always @(posedge clk) begin
    logic [64:0] m;
    if (rst_d1) begin
      cmp("reset out_valid", 64'(bus.out_valid), 64'd0);
      cmp("reset out_result", bus.out_result, 64'd0);
      cmp("reset out_tag", 64'(bus.out_tag), 64'd0);
      cmp("reset out_illegal", 64'(bus.out_illegal), 64'd0);
    end
    if (rst) begin
      cmp("in_ready during reset", 64'(bus.in_ready), 64'd0);
      model_q.delete();
    end else begin
      exp_ready = (model_q.size() < 2);
      cmp("in_ready", 64'(bus.in_ready), 64'(exp_ready));
      cmp("out_valid", 64'(bus.out_valid), 64'(model_q.size() > 0));
      if (model_q.size() > 0) begin
        cmp("out_result", bus.out_result, model_q[0].res);
        cmp("out_tag", 64'(bus.out_tag), 64'(model_q[0].tag));
        cmp("out_illegal", 64'(bus.out_illegal), 64'(model_q[0].ill));
      end
      if (bus.out_valid && bus.out_ready) begin
        drained_res[bus.out_tag]  = bus.out_result;
        drained_ill[bus.out_tag]  = bus.out_illegal;
        drained_seen[bus.out_tag] = 1'b1;
        drained_cyc[bus.out_tag]  = cyc;
      end
      if (flush) begin
        model_q.delete();
      end else begin
        if (model_q.size() > 0 && bus.out_ready) void'(model_q.pop_front());
        if (bus.in_valid && exp_ready) begin
          m = modelAlu(bus.in_ctrl, bus.in_a, bus.in_b);
          model_q.push_back('{res: m[63:0], tag: bus.in_tag, ill: m[64]});
        end
      end
    end
    rst_d1 = rst;
    cyc++;
  end

  task automatic applyStimulus(input logic [4:0] c, input logic [63:0] a, input logic [63:0] b,
                               input logic [7:0] tag);
    int budget;
    budget = 0;
    bus.in_ctrl  = c;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1) begin
      if (budget == 40) begin
        cmp("accept wait", 64'(bus.in_ready), 64'd1);
        break;
      end
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [4:0] c, input logic [63:0] a,
                             input logic [63:0] b, input logic [7:0] tag,
                             input logic [63:0] exp_res, input logic exp_ill);
    logic [64:0] m;
    m = modelAlu(c, a, b);
    cmp({name, " model result"}, m[63:0], exp_res);
    cmp({name, " model illegal"}, 64'(m[64]), 64'(exp_ill));
    cmp({name, " drained"}, 64'(drained_seen[tag]), 64'd1);
    cmp({name, " result"}, drained_res[tag], exp_res);
    cmp({name, " illegal"}, 64'(drained_ill[tag]), 64'(exp_ill));
  endtask

  task automatic addVec(input logic [4:0] c, input logic [63:0] a, input logic [63:0] b,
                        input logic [7:0] tag, input logic [63:0] res, input logic ill);
    vecs.push_back('{ctrl: c, a: a, b: b, tag: tag, res: res, ill: ill});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.in_ctrl = '0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
    for (int i = 0; i < 256; i++) begin
      drained_seen[i] = 1'b0; drained_res[i] = '0; drained_ill[i] = 1'b0; drained_cyc[i] = 0;
    end

    repeat (3) @(negedge clk);
    cmp("initial reset in_ready", 64'(bus.in_ready), 64'd0);
    cmp("initial reset out_valid", 64'(bus.out_valid), 64'd0);
    cmp("initial reset out_result", bus.out_result, 64'd0);
    rst = 1'b0;
    #1;
    cmp("in_ready after reset", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    $display("[TB] arithmetic, word and shift sweep");
    addVec(5'b00000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 8'd1, 64'd0, 1'b0);
    addVec(5'b01000, 64'd0, 64'd1, 8'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    addVec(5'b00010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 8'd3, 64'd1, 1'b0);
    addVec(5'b00011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 8'd4, 64'd0, 1'b0);
    addVec(5'b10000, 64'h7FFF_FFFF, 64'd1, 8'd5, 64'hFFFF_FFFF_8000_0000, 1'b0);
    addVec(5'b11101, 64'h8000_0000, 64'd4, 8'd6, 64'hFFFF_FFFF_F800_0000, 1'b0);
    addVec(5'b10101, 64'h8000_0000, 64'd4, 8'd7, 64'h0000_0000_0800_0000, 1'b0);
    addVec(5'b10001, 64'd1, 64'h25, 8'd8, 64'h20, 1'b0);
    addVec(5'b00001, 64'd1, 64'h41, 8'd9, 64'd2, 1'b0);
    addVec(5'b01101, 64'h8000_0000_0000_0000, 64'd63, 8'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    addVec(5'b10010, 64'd5, 64'd3, 8'd11, 64'd0, 1'b1);
    addVec(5'b00100, 64'hF0F0, 64'h0FF0, 8'd12, 64'hFF00, 1'b0);
    addVec(5'b00110, 64'hF0, 64'h0F, 8'd13, 64'hFF, 1'b0);
    addVec(5'b00111, 64'hF0, 64'h3C, 8'd14, 64'h30, 1'b0);
    addVec(5'b00101, 64'h8000_0000_0000_0000, 64'd63, 8'd15, 64'd1, 1'b0);
    addVec(5'b11000, 64'd0, 64'd1, 8'd16, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    foreach (vecs[i]) applyStimulus(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].tag);
    idle(3);
    foreach (vecs[i]) checkOutput($sformatf("op tag %0d", vecs[i].tag), vecs[i].ctrl, vecs[i].a,
                                  vecs[i].b, vecs[i].tag, vecs[i].res, vecs[i].ill);
    for (int t = 1; t < 16; t++)
      cmp($sformatf("drain spacing tag %0d", t + 1), 64'(drained_cyc[t + 1] - drained_cyc[t]), 64'd1);

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    applyStimulus(5'b00000, 64'd1, 64'd1, 8'd101);
    applyStimulus(5'b00000, 64'd2, 64'd2, 8'd102);
    bus.in_ctrl = 5'b00000; bus.in_a = 64'd3; bus.in_b = 64'd3; bus.in_tag = 8'd103;
    bus.in_valid = 1'b1;
    repeat (3) begin
      cmp("stall in_ready", 64'(bus.in_ready), 64'd0);
      cmp("stall out_tag", 64'(bus.out_tag), 64'd101);
      cmp("stall out_result", bus.out_result, 64'd2);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    applyStimulus(5'b00000, 64'd3, 64'd3, 8'd103);
    idle(3);
    checkOutput("bp tag 101", 5'b00000, 64'd1, 64'd1, 8'd101, 64'd2, 1'b0);
    checkOutput("bp tag 102", 5'b00000, 64'd2, 64'd2, 8'd102, 64'd4, 1'b0);
    checkOutput("bp tag 103", 5'b00000, 64'd3, 64'd3, 8'd103, 64'd6, 1'b0);
    cmp("bp spacing 102", 64'(drained_cyc[102] - drained_cyc[101]), 64'd1);
    cmp("bp spacing 103", 64'(drained_cyc[103] - drained_cyc[102]), 64'd1);

    $display("[TB] flush");
    bus.out_ready = 1'b0;
    applyStimulus(5'b00000, 64'd10, 64'd1, 8'd201);
    applyStimulus(5'b00000, 64'd20, 64'd1, 8'd202);
    bus.in_tag = 8'd203; bus.in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; bus.in_valid = 1'b0;
    cmp("flush out_valid", 64'(bus.out_valid), 64'd0);
    cmp("flush in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    bus.in_tag = 8'd204; bus.in_valid = 1'b1; flush = 1'b1;
    cmp("flush empty in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    flush = 1'b0; bus.in_valid = 1'b0;
    cmp("flush empty out_valid", 64'(bus.out_valid), 64'd0);
    idle(3);
    for (int t = 201; t <= 204; t++)
      cmp($sformatf("flushed tag %0d absent", t), 64'(drained_seen[t]), 64'd0);

    $display("[TB] reset mid-stream");
    bus.out_ready = 1'b0;
    applyStimulus(5'b00000, 64'd40, 64'd2, 8'd210);
    bus.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    cmp("mid reset in_ready", 64'(bus.in_ready), 64'd0);
    cmp("mid reset out_valid", 64'(bus.out_valid), 64'd0);
    cmp("mid reset out_result", bus.out_result, 64'd0);
    cmp("mid reset out_tag", 64'(bus.out_tag), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    cmp("ready after mid reset", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    applyStimulus(5'b00000, 64'd5, 64'd7, 8'd211);
    cmp("post reset latency valid", 64'(bus.out_valid), 64'd1);
    cmp("post reset latency tag", 64'(bus.out_tag), 64'd211);
    cmp("post reset latency result", bus.out_result, 64'd12);
    idle(3);
    checkOutput("post reset op", 5'b00000, 64'd5, 64'd7, 8'd211, 64'd12, 1'b0);
    cmp("reset-dropped tag 210 absent", 64'(drained_seen[210]), 64'd0);
    cmp("model empty at end", 64'(model_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage consumer of the 5-bit ALU control code that the ALU control decoder produces.
- Registers one operation per handshake, computes the RV64I/RV64I-W result, and presents it to the memory stage over a valid/ready interface.
- A 2-deep skid buffer means backpressure from the memory stage never creates a combinational ready path back into decode.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- TAG_W, 8, width of the sideband tag carried with each op (rd index, writeback enable, etc.).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; drops all held and incoming ops
- in_valid  in  1  op offered
- in_ready  out  1  stage can accept an op
- in_ctrl  in  5  ALU control code {word, alt, funct3}
- in_a  in  XLEN  operand A
- in_b  in  XLEN  operand B (register or immediate)
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_result  out  XLEN  ALU result
- out_tag  out  TAG_W  tag of the op in out_result
- out_illegal  out  1  op carried an unsupported control code

Behaviour:
- Control codes, XLEN ops:
  - 00000 add, 01000 sub
  - 00001 sll, 00010 slt, 00011 sltu, 00100 xor
  - 00101 srl, 01101 sra, 00110 or, 00111 and
- Control codes, word ops:
  - 10000 addw, 11000 subw, 10001 sllw, 10101 srlw, 11101 sraw
- Any other code: result 0, out_illegal=1, tag still passed through.
- Shift amount: in_b[5:0] for XLEN ops, in_b[4:0] for word ops.
- Word ops operate on in_a[31:0] and in_b[31:0], then sign-extend result bit 31 to 64 bits. srlw zero-fills from bit 31; sraw fills with in_a[31].
- slt/sltu produce 0 or 1 zero-extended. add/sub wrap modulo 2^64; no overflow flag.
- Result is computed combinationally from the inputs and captured at acceptance. Nothing is recomputed while an op is held.
- Storage: output register (OUT) plus skid register (SKID), each holding {result, tag, illegal, valid}.
- Accept rule: in_ready = ~SKID.valid & ~rst. An accept is a cycle with in_valid & in_ready.
- Drain rule: out_valid = OUT.valid. A drain is a cycle with out_valid & out_ready.
- Per-cycle update:
  - OUT empty, or draining: OUT loads SKID if SKID.valid (SKID clears), else loads the accepted op, else goes invalid.
  - OUT full and not draining: an accepted op goes to SKID.
  - SKID full and draining, with a new accept in the same cycle: SKID moves to OUT and the new op enters SKID. This cannot occur because in_ready=0 while SKID is full.
- Ordering is strict FIFO.
- Latency: an op accepted in cycle N is visible on out_* in cycle N+1 when OUT was empty or draining.
- Throughput is 1 op/cycle with out_ready held high.
- flush (has priority over everything except rst):
  - OUT.valid and SKID.valid clear next cycle.
  - An op presented in the flush cycle is not captured.
  - in_ready stays as computed, so an upstream pulse during flush is treated as dropped.
- Reset: out_valid=0, out_result=0, out_tag=0, out_illegal=0, SKID cleared, in_ready=0 while rst is high and 1 in the first cycle after.
  - Reset mid-transfer discards held ops with no partial output.
- out_* stay stable while out_valid & ~out_ready; payload changes only on a drain or flush.

Decomposition:
- Shared package alu_pkg holds the 5-bit control code constants (ALU_ADD … ALU_SRAW) and the field positions (word=bit4, alt=bit3, funct3=bits2:0). The ALU control decoder imports the same constants.
- One combinational sub-module, alu_core (ctrl, a, b -> result, illegal). alu_exec_stage contains only the skid/handshake logic around it.

Test Plan:
- Arithmetic sweep, out_ready=1: add 0xFFFF_FFFF_FFFF_FFFF+1 -> 0 next cycle; sub 0-1 -> 0xFFFF_FFFF_FFFF_FFFF; slt -1,1 -> 1; sltu -1,1 -> 0; one result per cycle, tags in order.
- Word ops: addw 0x7FFF_FFFF+1 -> 0xFFFF_FFFF_8000_0000; sraw 0x8000_0000 by 4 -> 0xFFFF_FFFF_F800_0000; srlw same -> 0x0000_0000_0800_0000; sllw by b=0x25 uses shamt 5.
- Shifts: sll 1 by b=0x41 -> 2 (shamt 1); sra 0x8000_0000_0000_0000 by 63 -> all ones; code 10010 -> result 0, out_illegal=1.
- Backpressure: out_ready=0, offer 3 ops tagged 1,2,3 -> tag1 in OUT, tag2 in SKID, in_ready=0, tag3 held upstream; then out_ready=1 -> tags drain 1,2,3 on consecutive cycles, out_* stable while stalled.
- Flush with OUT and SKID full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, no trace of the three ops ever appears.
- Reset mid-stream with OUT full -> outputs all zero, out_valid=0, in_ready=0 during reset; the first op after reset returns its correct result with latency 1.
